// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority,
// long-latency results (B) queue in a small FIFO and drain into idle slots.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_addr,
  input  logic [31:0]              b_data,
  output logic                     wEna,
  output logic [4:0]               wAddr,
  output logic [31:0]              wDin,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wena_q, wena_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdin_q, wdin_d;

  logic a_eff, full, push, pop, push_live;

  // Request qualification: A to r0 is an idle slot, B never pushes while full
  always_comb begin
    a_eff     = a_valid && (a_addr != 5'd0);
    full      = (count_q == CW'(DEPTH));
    push      = b_valid && !full;
    pop       = !a_eff && (count_q != CW'(0));
    push_live = (b_addr != 5'd0) && !(a_eff && (a_addr == b_addr));
  end

  // Next state: kill older same-address entries, arbitrate the write slot, update FIFO
  always_comb begin
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wena_d   = 1'b0;
    waddr_d  = waddr_q;
    wdin_d   = wdin_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (a_eff && (addr_q[i] == a_addr)) live_d[i] = 1'b0;
    end

    if (a_eff) begin
      wena_d  = 1'b1;
      waddr_d = a_addr;
      wdin_d  = a_data;
    end else if (pop) begin
      // dead heads still consume the slot, with the write suppressed
      wena_d = live_q[rd_ptr_q];
      if (live_q[rd_ptr_q]) begin
        waddr_d = addr_q[rd_ptr_q];
        wdin_d  = data_q[rd_ptr_q];
      end
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + AW'(1);
    end

    if (push) begin
      live_d[wr_ptr_q] = push_live;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Control and output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wena_q   <= 1'b0;
      waddr_q  <= '0;
      wdin_q   <= '0;
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wena_q   <= wena_d;
      waddr_q  <= waddr_d;
      wdin_q   <= wdin_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers and live bits
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= b_addr;
      data_q[wr_ptr_q] <= b_data;
    end
  end

  // Pending-write mask from live stored entries
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign b_ready = !full;
  assign wEna    = wena_q;
  assign wAddr   = waddr_q;
  assign wDin    = wdin_q;
  assign count   = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, b_ready, wEna;
  logic [4:0]    a_addr, b_addr, wAddr;
  logic [31:0]   a_data, b_data, wDin, pend_mask;
  logic [CW-1:0] count;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wEna(wEna), .wAddr(wAddr), .wDin(wDin),
    .pend_mask(pend_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } entry_t;

  entry_t      q[$];
  logic        exp_wena;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdin;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".wEna"},  32'(wEna),  32'(exp_wena));
    check_eq({tag, ".wAddr"}, 32'(wAddr), 32'(exp_waddr));
    check_eq({tag, ".wDin"},  wDin,       exp_wdin);
    check_eq({tag, ".count"}, 32'(count), 32'(q.size()));
    check_eq({tag, ".pend"},  pend_mask,  model_mask());
    check_eq({tag, ".ready"}, 32'(b_ready), 32'(q.size() < DEPTH));
  endtask

  // One clock cycle: drive at the falling edge, update model at rising edge, check at next fall
  task automatic step(input string tag,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bit a_eff, push, pop;
    entry_t h;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    a_eff = av && (aa != 5'd0);
    push  = bv && (q.size() < DEPTH);
    pop   = !a_eff && (q.size() > 0);
    @(posedge clk);
    if (a_eff) begin
      foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
      exp_wena = 1'b1; exp_waddr = aa; exp_wdin = ad;
    end else if (pop) begin
      h = q.pop_front();
      exp_wena = h.live;
      if (h.live) begin exp_waddr = h.addr; exp_wdin = h.data; end
    end else begin
      exp_wena = 1'b0;
    end
    if (push) q.push_back('{addr: ba, data: bd, live: (ba != 5'd0) && !(a_eff && aa == ba)});
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, $urandom, 1'b0, 5'(($urandom)), $urandom);
  endtask

  task automatic model_reset();
    q.delete();
    exp_wena = 1'b0; exp_waddr = '0; exp_wdin = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    // reset with arbitrary inputs
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_addr = 5'(($urandom)); a_data = $urandom;
      b_valid = 1'b1; b_addr = 5'(($urandom)); b_data = $urandom;
      @(negedge clk);
    end
    check_outputs("reset");
    rst_n = 1'b1;

    // A only: r5 then r0 (discarded)
    step("a_r5", 1'b1, 5'd5, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    check_eq("a_r5.data_const", wDin, 32'h1111_1111);
    step("a_r0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    check_eq("a_r0.wena_const", 32'(wEna), 32'd0);

    // B only: r7 pending then written
    step("b_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    check_eq("b_push.pend7", 32'(pend_mask[7]), 32'd1);
    idle("b_pop");
    check_eq("b_pop.data_const", wDin, 32'hDEAD_BEEF);
    check_eq("b_pop.pend_const", pend_mask, 32'd0);

    // Fill while A writes r9 every cycle, then drain
    for (int i = 1; i <= 4; i++)
      step("fill", 1'b1, 5'd9, 32'h9000_0000 + 32'(i), 1'b1, 5'(i), 32'hB000_0000 + 32'(i));
    check_eq("fill.ready_const", 32'(b_ready), 32'd0);
    check_eq("fill.count_const", 32'(count), 32'd4);
    step("full_push", 1'b1, 5'd9, 32'h9000_0005, 1'b1, 5'd12, 32'hB000_0012);
    for (int i = 1; i <= 4; i++) begin
      idle("drain");
      check_eq("drain.addr_const", 32'(wAddr), 32'(i));
    end
    idle("drain_empty");

    // Kill: queued r3 overtaken by an A write to r3
    step("kill_push", 1'b1, 5'd1, 32'h0000_0001, 1'b1, 5'd3, 32'hAAAA_0000);
    step("kill_a", 1'b1, 5'd3, 32'h0000_5555, 1'b0, 5'd0, 32'd0);
    check_eq("kill.pend3", 32'(pend_mask[3]), 32'd0);
    idle("kill_dead");
    check_eq("kill.dead_wena", 32'(wEna), 32'd0);

    // Same-cycle conflict and zero address
    step("same_cyc", 1'b1, 5'd6, 32'h0000_0A0A, 1'b1, 5'd6, 32'h0000_0B0B);
    idle("same_dead");
    step("zero_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_0001);
    idle("zero_pop");

    // Reset mid-drain discards queued entries
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1'b1, 5'd2, $urandom, 1'b1, 5'(10 + i), $urandom);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");
    idle("post_rst2");

    // Random traffic on a small address set to provoke kills and conflicts
    for (int i = 0; i < 3000; i++) begin
      logic av, bv;
      av = ($urandom_range(0, 99) < 45);
      bv = ($urandom_range(0, 99) < 55);
      step("rand", av, 5'($urandom_range(0, 7)), $urandom,
                   bv, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end for the 32×32 CPU register file. Merges two result producers into the single register-file write port: the in-order pipeline writeback stream (port A, never stalls) and a long-latency producer such as a memory load or multiply/divide unit (port B, valid/ready). Port B results are buffered in a small FIFO and drained into idle write slots. Drives the register file's `wEna`/`wAddr`/`wDin` from registers and exports a pending-write mask for the hazard/stall logic.

## Interface
- `DEPTH`, default 4: port-B FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  pipeline writeback request this cycle; always accepted.
- `a_addr`  in  5  destination register for port A.
- `a_data`  in  32  write data for port A.
- `b_valid`  in  1  long-latency result offered.
- `b_ready`  out  1  FIFO can accept; equals `!full`.
- `b_addr`  in  5  destination register for port B.
- `b_data`  in  32  write data for port B.
- `wEna`  out  1  register-file write enable (registered).
- `wAddr`  out  5  register-file write address (registered).
- `wDin`  out  32  register-file write data (registered).
- `pend_mask`  out  32  bit r = 1 when a live FIFO entry targets register r; bit 0 is always 0.
- `count`  out  log2(DEPTH)+1  FIFO occupancy, live and dead entries.

## Operation
- Reset (async, `rst_n`=0): `wEna`=0, `wAddr`=0, `wDin`=0, FIFO empty, `count`=0, `b_ready`=1, `pend_mask`=0, all live bits cleared.
- An **effective A write** is `a_valid`=1 with `a_addr`≠0. `a_valid` with `a_addr`=0 is discarded and counts as an idle slot.
- **Port A priority:** an effective A write in cycle N registers `wEna`=1, `wAddr`=`a_addr`, `wDin`=`a_data` at edge N+1. The FIFO does not pop in that cycle.
- **Port B push:** a push occurs when `b_valid`=1 and `b_ready`=1. It writes `b_addr`/`b_data` to the tail with live=1.
  - live=0 if `b_addr`=0.
  - live=0 if an effective A write to the same address occurs in the same cycle.
- **Kill rule (WAW):** an effective A write is younger than every queued B entry. All queued entries with an address equal to `a_addr` are set live=0 at the same edge.
- **Pop:** a pop occurs in any cycle with no effective A write and a non-empty FIFO.
  - The head is removed.
  - If the head is live: `wEna`=1, `wAddr`/`wDin` = head fields at the next edge.
  - If the head is dead: it is removed with `wEna`=0. A dead entry consumes one cycle.
- When neither an A write nor a pop occurs, `wEna`=0 at the next edge. `wAddr` and `wDin` hold their last values.
- Push and pop may occur in the same cycle; `count` is then unchanged.
- `b_ready` depends only on `full`. There is no push-while-full, even if a pop occurs in the same cycle.
- The read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `full` = (`count`==DEPTH).
- `pend_mask` is combinational from the live entries currently stored, i.e. the state after the last edge.

## Timing
- Port A latency: request in cycle N, write visible at the register file after edge N+2. `wEna` is high during cycle N+1.
- Port B minimum latency: push in cycle N, pop in N+1, `wEna` high in cycle N+2, provided no A writes occur.
- Port B starvation is possible under back-to-back effective A writes. The pipeline uses `pend_mask` to stall reads of pending registers.
- `b_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from a full FIFO.
- Asserting `rst_n` mid-drain discards all queued entries. No write is issued after reset deassertion until a new request arrives.

## Test plan
- **Reset:** hold `rst_n`=0 with arbitrary inputs → `wEna`=0, `wAddr`=0, `wDin`=0, `b_ready`=1, `count`=0, `pend_mask`=0.
- **A only:** A writes r5=0x11111111 at N and r0=0xFFFFFFFF at N+1 → `wEna`=1 with r5/0x11111111 in N+1; `wEna`=0 in N+2.
- **B only:** push r7=0xDEADBEEF at N with A idle → `pend_mask`[7]=1 in N+1; `wEna`=1 with r7/0xDEADBEEF in N+2; `pend_mask`=0 in N+2.
- **Fill, starve, drain (DEPTH=4):**
  - Push r1..r4 during continuous A writes to r9 → `b_ready`=0 after the 4th push and `count`=4.
  - Stop A → r1..r4 are written in push order on 4 consecutive cycles; `b_ready`=1 again after the first pop.
- **Kill:** push r3=0xAAAA0000, then A writes r3=0x5555 before the pop → the single r3 write is 0x5555; the dead entry costs one cycle with `wEna`=0; `pend_mask`[3] clears at the kill edge.
- **Same-cycle conflict and zero address:**
  - Push r6 and an A write to r6 in the same cycle → only the A value is written.
  - Push r0=0x1 → an entry is counted but no write occurs.
